tc_latch_wr_ctrl: RTL and testbench

Write-side controller for latch-based storage arrays built from enable-high, async-active-low-reset latch cells. It accepts write requests over a valid/ready handshake and holds the write data stable in flops. It drives one glitch-free gated enable per latch byte-lane (through `tc_clk_gating` cells) so that the selected latches are transparent for exactly one clock-high phase. It sits between a bus/register-file front end and the latch array, which provides the other end of the latch enable/data interface.

---
 rtl/tc_latch_wr_ctrl.sv | 143 ++++++++++++++
 tb/tb_tc_latch_wr_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tc_latch_wr_ctrl.sv
// Write-side controller for latch-based storage: handshake capture, one-phase gated enables per byte lane.
// Optional per-lane byte enables are built in when TC_LATCH_WR_CTRL_BE_EN is defined.
//
// state | meaning
// IDLE  | waiting for a request, ready high
// SETUP | data/enables registered, gate opens during next high phase, ready low
// PULSE | latches transparent this high phase, done/err pulse, next request may be accepted

module tc_clk_gating (
   input  logic clk_i,
   input  logic en_i,
   input  logic test_en_i,
   output logic clk_o
);

   logic en_l;

   // Enable captured only while clk_i is low, so clk_o cannot glitch.
   always_latch begin
      if (!clk_i) en_l = en_i | test_en_i;
   end

   assign clk_o = clk_i & en_l;

endmodule

module tc_latch_wr_ctrl #(
   parameter int NumWords  = 8,
   parameter int DataWidth = 32
) (
   input  logic                                  clk_i,
   input  logic                                  rst_ni,
   input  logic                                  test_en_i,
   input  logic                                  req_valid_i,
   output logic                                  req_ready_o,
   input  logic [$clog2(NumWords)-1:0]           req_addr_i,
   input  logic [DataWidth-1:0]                  req_wdata_i,
   input  logic [DataWidth/8-1:0]                req_be_i,
   output logic [NumWords*(DataWidth/8)-1:0]     latch_en_o,
   output logic [DataWidth-1:0]                  latch_data_o,
   output logic                                  done_o,
   output logic                                  err_o
);

   localparam int NumBytes = DataWidth / 8;
   localparam int AddrW    = $clog2(NumWords);
   localparam int NumEn    = NumWords * NumBytes;
   localparam logic [AddrW:0] NumWordsC = (AddrW + 1)'(NumWords);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      PULSE = 2'd2
   } state_e;

   state_e               state_q, state_d;
   logic [AddrW-1:0]     addr_q, addr_d;
   logic [DataWidth-1:0] data_q, data_d;
   logic [NumEn-1:0]     en_q, en_d;
   logic                 done_q, done_d;
   logic                 err_q, err_d;
   logic [NumBytes-1:0]  be_mask;
   logic                 ready;
   logic                 hs;
   logic                 in_range;

`ifdef TC_LATCH_WR_CTRL_BE_EN
   assign be_mask = req_be_i;
`else
   logic unused_be;
   assign unused_be = ^req_be_i;
   assign be_mask   = '1;
`endif

   assign ready    = (state_q != SETUP);
   assign hs       = req_valid_i & ready;
   assign in_range = ({1'b0, addr_q} < NumWordsC);

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      data_d  = data_q;
      en_d    = '0;
      done_d  = 1'b0;
      err_d   = 1'b0;

      unique case (state_q)
         IDLE:    if (hs) state_d = SETUP;
         SETUP:   state_d = PULSE;
         PULSE:   state_d = hs ? SETUP : IDLE;
         default: state_d = IDLE;
      endcase

      if (hs) begin
         addr_d = req_addr_i;
         data_d = req_wdata_i;
         // Out-of-range addresses match no word, so no enable is raised.
         for (int w = 0; w < NumWords; w++) begin
            for (int b = 0; b < NumBytes; b++) begin
               en_d[w*NumBytes+b] = (req_addr_i == AddrW'(w)) & be_mask[b];
            end
         end
      end

      if (state_q == SETUP) begin
         done_d = in_range;
         err_d  = ~in_range;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         addr_q  <= '0;
         data_q  <= '0;
         en_q    <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         en_q    <= en_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   for (genvar g = 0; g < NumEn; g++) begin : g_cg
      tc_clk_gating u_cg (
         .clk_i     (clk_i),
         .en_i      (en_q[g]),
         .test_en_i (test_en_i),
         .clk_o     (latch_en_o[g])
      );
   end

   assign req_ready_o  = ready;
   assign latch_data_o = data_q;
   assign done_o       = done_q;
   assign err_o        = err_q;

endmodule

// File: tb/tb_tc_latch_wr_ctrl.sv
// Directed bench for tc_latch_wr_ctrl with a byte-lane latch array model (NumWords=6).
// Expectations for the byte-enable test follow TC_LATCH_WR_CTRL_BE_EN.

module tb_tc_latch_wr_ctrl;

   localparam int NW = 6;
   localparam int DW = 32;
   localparam int NB = DW / 8;
   localparam int NE = NW * NB;
   localparam int AW = $clog2(NW);

   logic          clk;
   logic          rst_n;
   logic          test_en;
   logic          req_valid;
   logic          req_ready;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic [NB-1:0] req_be;
   logic [NE-1:0] latch_en;
   logic [DW-1:0] latch_data;
   logic          done;
   logic          err;

   int pass_cnt = 0;
   int chk_cnt  = 0;

   logic [DW-1:0] mem [NW];
   int            pulses [NE];
   int            viol = 0;

   tc_latch_wr_ctrl #(.NumWords(NW), .DataWidth(DW)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .test_en_i    (test_en),
      .req_valid_i  (req_valid),
      .req_ready_o  (req_ready),
      .req_addr_i   (req_addr),
      .req_wdata_i  (req_wdata),
      .req_be_i     (req_be),
      .latch_en_o   (latch_en),
      .latch_data_o (latch_data),
      .done_o       (done),
      .err_o        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Latch array model: bytes whose enable is high take latch_data during the high phase.
   always begin
      @(posedge clk);
      #1;
      if (rst_n) begin
         for (int i = 0; i < NE; i++) begin
            if (latch_en[i]) begin
               mem[i/NB][(i%NB)*8 +: 8] = latch_data[(i%NB)*8 +: 8];
               pulses[i] = pulses[i] + 1;
            end
         end
      end
   end

   always @(negedge rst_n) begin
      for (int w = 0; w < NW; w++) mem[w] = '0;
   end

   always @(latch_data) begin
      if (latch_en != '0) viol = viol + 1;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Drive a request and return just after the accepting edge, valid dropped.
   task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] be);
      int n;
      n = 0;
      req_valid = 1'b1;
      req_addr  = a;
      req_wdata = d;
      req_be    = be;
      while (!req_ready && n < 20) begin
         tick();
         n++;
      end
      if (!req_ready) begin
         chk_cnt++;
         $display("FAIL send_timeout: ready=%0b after %0d cycles, required 1", req_ready, n);
      end
      tick();
      req_valid = 1'b0;
   endtask

   task automatic test_reset;
      rst_n     = 1'b0;
      test_en   = 1'b0;
      req_valid = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      req_be    = '0;
      for (int i = 0; i < NE; i++) pulses[i] = 0;
      tick();
      tick();
      rst_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick();
         chk_cnt++;
         if (req_ready !== 1'b1) $display("FAIL reset_ready: got %0b, required 1", req_ready);
         else pass_cnt++;
         chk_cnt++;
         if (latch_en !== '0) $display("FAIL reset_en: got %h, required 0", latch_en);
         else pass_cnt++;
         chk_cnt++;
         if (latch_data !== '0) $display("FAIL reset_data: got %h, required 0", latch_data);
         else pass_cnt++;
         chk_cnt++;
         if (done !== 1'b0 || err !== 1'b0) $display("FAIL reset_done: done=%0b err=%0b, required 0/0", done, err);
         else pass_cnt++;
      end
   endtask

   task automatic test_single_write;
      send(3'd3, 32'hDEADBEEF, 4'hF);
      chk_cnt++;
      if (req_ready !== 1'b0 || latch_en !== '0) $display("FAIL single_setup: ready=%0b en=%h, required 0/0", req_ready, latch_en);
      else pass_cnt++;
      chk_cnt++;
      if (latch_data !== 32'hDEADBEEF) $display("FAIL single_data: got %h, required deadbeef", latch_data);
      else pass_cnt++;
      tick();
      chk_cnt++;
      if (latch_en !== 24'h00F000) $display("FAIL single_pulse: got %h, required 00f000", latch_en);
      else pass_cnt++;
      chk_cnt++;
      if (done !== 1'b1 || err !== 1'b0) $display("FAIL single_done: done=%0b err=%0b, required 1/0", done, err);
      else pass_cnt++;
      tick();
      chk_cnt++;
      if (latch_en !== '0 || done !== 1'b0) $display("FAIL single_after: en=%h done=%0b, required 0/0", latch_en, done);
      else pass_cnt++;
      for (int w = 0; w < NW; w++) begin
         chk_cnt++;
         if (mem[w] !== ((w == 3) ? 32'hDEADBEEF : 32'h0))
            $display("FAIL single_mem%0d: got %h, required %h", w, mem[w], (w == 3) ? 32'hDEADBEEF : 32'h0);
         else pass_cnt++;
      end
   endtask

   task automatic test_back_to_back;
      logic [DW-1:0] dat [4];
      logic          exp_rdy;
      dat[0] = 32'h0A0A0A0A;
      dat[1] = 32'h1B1B1B1B;
      dat[2] = 32'h2C2C2C2C;
      dat[3] = 32'h3D3D3D3D;
      viol = 0;
      req_valid = 1'b1;
      req_addr  = 3'd0;
      req_wdata = dat[0];
      req_be    = 4'hF;
      for (int k = 0; k < 8; k++) begin
         tick();
         exp_rdy = (k % 2 == 1);
         chk_cnt++;
         if (req_ready !== exp_rdy) $display("FAIL b2b_ready%0d: got %0b, required %0b", k, req_ready, exp_rdy);
         else pass_cnt++;
         if (k % 2 == 0) begin
            chk_cnt++;
            if (latch_data !== dat[k/2]) $display("FAIL b2b_data%0d: got %h, required %h", k, latch_data, dat[k/2]);
            else pass_cnt++;
            if (k < 6) begin
               req_addr  = AW'(k/2 + 1);
               req_wdata = dat[k/2 + 1];
            end else begin
               req_valid = 1'b0;
            end
         end
      end
      tick();
      for (int w = 0; w < 4; w++) begin
         chk_cnt++;
         if (mem[w] !== dat[w]) $display("FAIL b2b_mem%0d: got %h, required %h", w, mem[w], dat[w]);
         else pass_cnt++;
      end
      chk_cnt++;
      if (viol !== 0) $display("FAIL b2b_data_stable: %0d changes under enable, required 0", viol);
      else pass_cnt++;
   endtask

   task automatic test_byte_enable;
      logic [DW-1:0] exp_word;
      logic [NE-1:0] exp_en;
`ifdef TC_LATCH_WR_CTRL_BE_EN
      exp_word = 32'hFF22FF44;
      exp_en   = 24'h000050;
`else
      exp_word = 32'h11223344;
      exp_en   = 24'h0000F0;
`endif
      send(3'd1, 32'hFFFFFFFF, 4'hF);
      tick();
      tick();
      chk_cnt++;
      if (mem[1] !== 32'hFFFFFFFF) $display("FAIL be_preload: got %h, required ffffffff", mem[1]);
      else pass_cnt++;
      send(3'd1, 32'h11223344, 4'b0101);
      tick();
      chk_cnt++;
      if (latch_en !== exp_en) $display("FAIL be_pulse: got %h, required %h", latch_en, exp_en);
      else pass_cnt++;
      tick();
      chk_cnt++;
      if (mem[1] !== exp_word) $display("FAIL be_word: got %h, required %h", mem[1], exp_word);
      else pass_cnt++;
   endtask

   task automatic test_out_of_range;
      logic [DW-1:0] snap [NW];
      int            tot0, tot1;
      for (int w = 0; w < NW; w++) snap[w] = mem[w];
      tot0 = 0;
      for (int i = 0; i < NE; i++) tot0 += pulses[i];
      send(3'd7, 32'hCAFEF00D, 4'hF);
      tick();
      chk_cnt++;
      if (err !== 1'b1 || done !== 1'b0) $display("FAIL oor_err: err=%0b done=%0b, required 1/0", err, done);
      else pass_cnt++;
      chk_cnt++;
      if (latch_en !== '0) $display("FAIL oor_pulse: got %h, required 0", latch_en);
      else pass_cnt++;
      tick();
      chk_cnt++;
      if (err !== 1'b0) $display("FAIL oor_err_clear: got %0b, required 0", err);
      else pass_cnt++;
      tot1 = 0;
      for (int i = 0; i < NE; i++) tot1 += pulses[i];
      chk_cnt++;
      if (tot1 !== tot0) $display("FAIL oor_pulse_count: got %0d, required %0d", tot1, tot0);
      else pass_cnt++;
      for (int w = 0; w < NW; w++) begin
         chk_cnt++;
         if (mem[w] !== snap[w]) $display("FAIL oor_mem%0d: got %h, required %h", w, mem[w], snap[w]);
         else pass_cnt++;
      end
   endtask

   task automatic test_reset_mid;
      int p0;
      p0 = pulses[2*NB];
      send(3'd2, 32'h5A5A5A5A, 4'hF);
      rst_n = 1'b0;
      tick();
      chk_cnt++;
      if (latch_en !== '0) $display("FAIL rstmid_en: got %h, required 0", latch_en);
      else pass_cnt++;
      chk_cnt++;
      if (req_ready !== 1'b1 || latch_data !== '0) $display("FAIL rstmid_regs: ready=%0b data=%h, required 1/0", req_ready, latch_data);
      else pass_cnt++;
      rst_n = 1'b1;
      tick();
      tick();
      chk_cnt++;
      if (pulses[2*NB] !== p0) $display("FAIL rstmid_pulse: count %0d, required %0d", pulses[2*NB], p0);
      else pass_cnt++;
      chk_cnt++;
      if (mem[2] !== '0 || done !== 1'b0) $display("FAIL rstmid_mem: mem=%h done=%0b, required 0/0", mem[2], done);
      else pass_cnt++;
   endtask

   task automatic test_test_en;
      test_en = 1'b1;
      @(negedge clk);
      tick();
      chk_cnt++;
      if (latch_en !== {NE{1'b1}}) $display("FAIL testen_high: got %h, required ffffff", latch_en);
      else pass_cnt++;
      #5;
      chk_cnt++;
      if (latch_en !== '0) $display("FAIL testen_low: got %h, required 0", latch_en);
      else pass_cnt++;
      test_en = 1'b0;
      tick();
      chk_cnt++;
      if (latch_en !== '0) $display("FAIL testen_off: got %h, required 0", latch_en);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_back_to_back();
      test_byte_enable();
      test_out_of_range();
      test_reset_mid();
      test_test_en();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, required completion");
      $fatal(1);
   end

endmodule
